pu_or1k_pfpu32_addsub_ctrl: RTL and testbench

Controller that shares the 3-stage pfpu32 add/sub pipeline between two requesters (e.g. FPU issue and the multiply-add sequencer). It does round-robin arbitration, generates the pipeline `start`/`adv`/`flush` controls, and carries requester ID and tag alongside the datapath so each result returns to its owner. It applies output back-pressure by freezing the pipeline, and supports a drain mode for exception/context-switch entry.

---
 rtl/pu_or1k_pfpu32_pkg.sv | 18 +
 rtl/pu_or1k_rr_arb2.sv | 36 +++
 rtl/pu_or1k_pfpu32_addsub_ctrl.sv | 139 +++++++++++++
 tb/tb_pu_or1k_pfpu32_addsub_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pu_or1k_pfpu32_pkg.sv
// Shared constants and types for control of the pfpu32 add/sub pipeline.
package pu_or1k_pfpu32_pkg;

  localparam int unsigned PFPU32_ADDSUB_LAT = 3;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } addsub_ctrl_state_t;

  // Owner bookkeeping carried alongside one add/sub pipeline stage.
  typedef struct packed {
    logic valid;
    logic id;
  } addsub_shadow_t;

endpackage

// File: rtl/pu_or1k_rr_arb2.sv
// Two-requester round-robin arbiter. The grant is combinational, and the
// last-winner pointer advances only when the grant is actually used.
module pu_or1k_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  logic last_q, last_d;

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = last_q ? 2'b01 : 2'b10;
    end
  end

  always_comb begin
    last_d = last_q;
    if (en_i && (gnt_o != 2'b00)) begin
      last_d = gnt_o[1];
    end
  end

  // Reset to 1 so that req0 wins the first contested grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/pu_or1k_pfpu32_addsub_ctrl.sv
// Shares the 3-stage pfpu32 add/sub between two requesters. It tracks the owner
// and tag of each op, freezes on result back-pressure and supports draining.
module pu_or1k_pfpu32_addsub_ctrl
  import pu_or1k_pfpu32_pkg::*;
#(
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             drain_i,
  input  logic             req0_valid_i,
  input  logic             req0_is_sub_i,
  input  logic [TAG_W-1:0] req0_tag_i,
  output logic             req0_ready_o,
  input  logic             req1_valid_i,
  input  logic             req1_is_sub_i,
  input  logic [TAG_W-1:0] req1_tag_i,
  output logic             req1_ready_o,
  output logic [1:0]       grant_o,
  output logic             start_o,
  output logic             adv_o,
  output logic             is_sub_o,
  output logic             flush_o,
  input  logic             add_rdy_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic             res_id_o,
  output logic [TAG_W-1:0] res_tag_o,
  output logic [1:0]       inflight_o,
  output logic             drained_o
);

  localparam int unsigned Lat = PFPU32_ADDSUB_LAT;

  addsub_ctrl_state_t state_q, state_d;
  addsub_shadow_t     shadow_q [Lat];
  addsub_shadow_t     shadow_d [Lat];
  logic [TAG_W-1:0]   tag_q    [Lat];
  logic [TAG_W-1:0]   tag_d    [Lat];
  logic [1:0]         inflight_q, inflight_d;
  logic [1:0]         arb_gnt;
  logic               issue_ok, issue, res_xfer;

  // An unaccepted result at the tail freezes every stage.
  assign adv_o    = rst | ~add_rdy_i | res_ready_i;
  assign flush_o  = rst | flush_i;
  assign issue_ok = (state_q == StRun) & ~drain_i & ~flush_o & adv_o;

  pu_or1k_rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i ({req1_valid_i, req0_valid_i}),
    .en_i  (issue),
    .gnt_o (arb_gnt)
  );

  assign grant_o      = issue_ok ? arb_gnt : 2'b00;
  assign issue        = |grant_o;
  assign start_o      = issue;
  assign req0_ready_o = grant_o[0];
  assign req1_ready_o = grant_o[1];
  assign is_sub_o     = (grant_o[0] & req0_is_sub_i) | (grant_o[1] & req1_is_sub_i);

  assign res_valid_o = add_rdy_i;
  assign res_xfer    = add_rdy_i & res_ready_i;
  assign res_id_o    = shadow_q[Lat-1].id;
  assign res_tag_o   = tag_q[Lat-1];
  assign inflight_o  = inflight_q;
  assign drained_o   = (state_q == StDrain) && (inflight_q == 2'd0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  state_d = StRun;
      StRun:   if (drain_i) state_d = StDrain;
      StDrain: if (!drain_i) state_d = StRun;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    for (int unsigned i = 0; i < Lat; i++) begin
      shadow_d[i] = shadow_q[i];
      tag_d[i]    = tag_q[i];
    end
    if (flush_i) begin
      for (int unsigned i = 0; i < Lat; i++) begin
        shadow_d[i] = '0;
        tag_d[i]    = '0;
      end
    end else if (adv_o) begin
      for (int unsigned i = 1; i < Lat; i++) begin
        shadow_d[i] = shadow_q[i-1];
        tag_d[i]    = tag_q[i-1];
      end
      shadow_d[0].valid = issue;
      shadow_d[0].id    = grant_o[1];
      tag_d[0]          = grant_o[1] ? req1_tag_i : (grant_o[0] ? req0_tag_i : '0);
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    if (flush_i) begin
      inflight_d = 2'd0;
    end else if (issue && !res_xfer) begin
      inflight_d = inflight_q + 2'd1;
    end else if (!issue && res_xfer) begin
      inflight_d = inflight_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      inflight_q <= 2'd0;
      for (int unsigned i = 0; i < Lat; i++) begin
        shadow_q[i] <= '0;
        tag_q[i]    <= '0;
      end
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      for (int unsigned i = 0; i < Lat; i++) begin
        shadow_q[i] <= shadow_d[i];
        tag_q[i]    <= tag_d[i];
      end
    end
  end

  // A full pipe can only take a new op while its tail result leaves.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(issue && !res_xfer && (inflight_q == 2'd3)));

  a_res_owned: assert property (@(posedge clk) disable iff (rst)
    add_rdy_i |-> shadow_q[Lat-1].valid);

endmodule

// File: tb/tb_pu_or1k_pfpu32_addsub_ctrl.sv
// Bench: directed vector table, corner-case sequences and random traffic,
// all checked against a queue-based model of ops in flight.
module tb_pu_or1k_pfpu32_addsub_ctrl;

  localparam int TW = 4;

  logic          clk;
  logic          rst, flush_i, drain_i, res_ready;
  logic          r0v, r1v, r0s, r1s;
  logic [TW-1:0] r0t, r1t;
  logic          r0rdy, r1rdy, start, adv, is_sub, flush_o, add_rdy, res_valid, res_id, drained;
  logic [1:0]    grant, inflight;
  logic [TW-1:0] res_tag;
  logic [2:0]    ap;

  pu_or1k_pfpu32_addsub_ctrl #(.TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .drain_i(drain_i),
    .req0_valid_i(r0v), .req0_is_sub_i(r0s), .req0_tag_i(r0t), .req0_ready_o(r0rdy),
    .req1_valid_i(r1v), .req1_is_sub_i(r1s), .req1_tag_i(r1t), .req1_ready_o(r1rdy),
    .grant_o(grant), .start_o(start), .adv_o(adv), .is_sub_o(is_sub), .flush_o(flush_o),
    .add_rdy_i(add_rdy), .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_id_o(res_id), .res_tag_o(res_tag), .inflight_o(inflight), .drained_o(drained)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the add/sub datapath: a 3-deep valid pipe obeying adv/flush.
  always_ff @(posedge clk) begin
    if (flush_o) ap <= 3'b000;
    else if (adv) ap <= {ap[1:0], start};
  end
  assign add_rdy = ap[2];

  int total = 0;
  int bad = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: ops in flight, oldest first; age counts the advances since issue.
  typedef struct {int id; int tag; int age;} op_t;
  op_t q[$];
  int  m_state;  // 0 idle, 1 run, 2 drain
  int  m_last;
  int  m_gnt;
  bit  m_adv, m_fr;

  task automatic model_check();
    bit fr, e_adv, ok;
    int e_gnt;
    fr    = (q.size() > 0) && (q[0].age == 3);
    e_adv = rst || !fr || res_ready;
    ok    = !rst && (m_state == 1) && !drain_i && !flush_i && e_adv;
    e_gnt = 0;
    if (ok) begin
      if (r0v && r1v) e_gnt = (m_last != 0) ? 1 : 2;
      else if (r0v)   e_gnt = 1;
      else if (r1v)   e_gnt = 2;
    end
    cmp("m_adv", adv, e_adv);
    cmp("m_flush", flush_o, rst || flush_i);
    cmp("m_grant", grant, e_gnt);
    cmp("m_ready0", r0rdy, e_gnt == 1);
    cmp("m_ready1", r1rdy, e_gnt == 2);
    cmp("m_start", start, e_gnt != 0);
    cmp("m_is_sub", is_sub, (e_gnt == 1) ? r0s : ((e_gnt == 2) ? r1s : 1'b0));
    cmp("m_res_valid", res_valid, fr);
    cmp("m_inflight", inflight, q.size());
    cmp("m_drained", drained, (m_state == 2) && (q.size() == 0));
    if (fr) begin
      cmp("m_res_id", res_id, q[0].id);
      cmp("m_res_tag", res_tag, q[0].tag);
    end
    m_gnt = e_gnt;
    m_adv = e_adv;
    m_fr  = fr;
  endtask

  task automatic model_update();
    op_t n;
    if (rst) begin
      q.delete();
      m_state = 0;
      m_last  = 1;
    end else begin
      if (m_gnt != 0) m_last = (m_gnt == 2) ? 1 : 0;
      if (flush_i) begin
        q.delete();
      end else if (m_adv) begin
        if (m_fr) void'(q.pop_front());
        foreach (q[i]) q[i].age++;
        if (m_gnt != 0) begin
          n.id  = (m_gnt == 2) ? 1 : 0;
          n.tag = (m_gnt == 2) ? int'(r1t) : int'(r0t);
          n.age = 1;
          q.push_back(n);
        end
      end
      case (m_state)
        0: m_state = 1;
        1: if (drain_i) m_state = 2;
        default: if (!drain_i) m_state = 1;
      endcase
    end
  endtask

  task automatic drive(input bit v0, input bit v1, input bit rr, input bit dr, input bit fl);
    r0v = v0; r1v = v1; res_ready = rr; drain_i = dr; flush_i = fl;
    r0s = 1'($urandom_range(0, 1));
    r1s = 1'($urandom_range(0, 1));
    r0t = 4'($urandom_range(0, 15));
    r1t = 4'($urandom_range(0, 15));
  endtask

  task automatic pre();
    #2;
    model_check();
  endtask

  task automatic post();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic check_reset();
    cmp("rst_ready0", r0rdy, 0);
    cmp("rst_ready1", r1rdy, 0);
    cmp("rst_grant", grant, 0);
    cmp("rst_start", start, 0);
    cmp("rst_is_sub", is_sub, 0);
    cmp("rst_flush_o", flush_o, 1);
    cmp("rst_adv", adv, 1);
    cmp("rst_res_id", res_id, 0);
    cmp("rst_res_tag", res_tag, 0);
    cmp("rst_inflight", inflight, 0);
    cmp("rst_drained", drained, 0);
  endtask

  task automatic empty_pipe();
    int k;
    k = 0;
    while (inflight != 0 && k < 10) begin
      drive(0, 0, 1, 0, 0); pre(); post();
      k++;
    end
    cmp("empty_pipe_timeout", inflight, 0);
  endtask

  typedef struct {
    bit r0v, r1v, s0, s1;
    bit [TW-1:0] t0, t1;
    bit rr;
    bit [1:0] gnt;
    bit sub, rv, id;
    bit [TW-1:0] tag;
    int inf;
  } vec_t;
  vec_t tbl[16];

  initial begin
    int last_x, first_d, k;
    tbl[0]  = '{1, 0, 1, 0, 5, 0, 1, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 1, 0, 5, 0, 1, 1, 1, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
    tbl[3]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
    tbl[4]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 5, 1};
    tbl[5]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    tbl[6]  = '{1, 1, 0, 1, 3, 9, 1, 2, 1, 0, 0, 0, 0};
    tbl[7]  = '{1, 1, 0, 1, 3, 9, 1, 1, 0, 0, 0, 0, 1};
    tbl[8]  = '{1, 1, 0, 1, 3, 9, 1, 2, 1, 0, 0, 0, 2};
    tbl[9]  = '{1, 1, 0, 1, 3, 9, 1, 1, 0, 1, 1, 9, 3};
    tbl[10] = '{1, 1, 0, 1, 3, 9, 1, 2, 1, 1, 0, 3, 3};
    tbl[11] = '{1, 1, 0, 1, 3, 9, 1, 1, 0, 1, 1, 9, 3};
    tbl[12] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 3, 3};
    tbl[13] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 9, 2};
    tbl[14] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 3, 1};
    tbl[15] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};

    rst = 1'b1;
    drive(0, 0, 1, 0, 0);
    @(posedge clk);
    q.delete(); m_state = 0; m_last = 1;
    @(negedge clk);
    pre(); check_reset(); post();
    rst = 1'b0;

    // Directed vectors: single op latency, then alternating contention.
    for (int i = 0; i < 16; i++) begin
      r0v = tbl[i].r0v; r1v = tbl[i].r1v; r0s = tbl[i].s0; r1s = tbl[i].s1;
      r0t = tbl[i].t0;  r1t = tbl[i].t1;  res_ready = tbl[i].rr;
      drain_i = 1'b0; flush_i = 1'b0;
      pre();
      cmp($sformatf("vec%0d_grant", i), grant, tbl[i].gnt);
      cmp($sformatf("vec%0d_start", i), start, tbl[i].gnt != 0);
      cmp($sformatf("vec%0d_is_sub", i), is_sub, tbl[i].sub);
      cmp($sformatf("vec%0d_res_valid", i), res_valid, tbl[i].rv);
      cmp($sformatf("vec%0d_inflight", i), inflight, tbl[i].inf);
      if (tbl[i].rv) begin
        cmp($sformatf("vec%0d_res_id", i), res_id, tbl[i].id);
        cmp($sformatf("vec%0d_res_tag", i), res_tag, tbl[i].tag);
      end
      post();
    end

    // Back-pressure: fill, hold the result for 4 cycles, release.
    empty_pipe();
    for (int i = 0; i < 3; i++) begin drive(1, 1, 1, 0, 0); pre(); post(); end
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 0, 0, 0); pre();
      cmp("stall_adv", adv, 0);
      cmp("stall_ready", {r1rdy, r0rdy}, 0);
      cmp("stall_res_valid", res_valid, 1);
      cmp("stall_inflight", inflight, 3);
      post();
    end
    drive(1, 1, 1, 0, 0); pre();
    cmp("release_start", start, 1);
    post();
    drive(0, 0, 1, 0, 0); pre();
    cmp("release_next_res", res_valid, 1);
    post();

    // Flush with a full pipe.
    empty_pipe();
    for (int i = 0; i < 3; i++) begin drive(1, 1, 1, 0, 0); pre(); post(); end
    drive(1, 1, 1, 0, 1); pre();
    cmp("flush_inflight_before", inflight, 3);
    cmp("flush_flush_o", flush_o, 1);
    cmp("flush_no_issue", start, 0);
    post();
    drive(1, 1, 1, 0, 0); pre();
    cmp("flush_inflight_after", inflight, 0);
    cmp("flush_stale_rdy", res_valid, 0);
    cmp("flush_reissue", start, 1);
    post();

    // Drain with two ops in flight and both requesters waiting.
    empty_pipe();
    drive(1, 0, 1, 0, 0); pre(); post();
    drive(0, 1, 1, 0, 0); pre(); post();
    last_x = -1; first_d = -1;
    for (k = 0; k < 8; k++) begin
      drive(1, 1, 1, 1, 0); pre();
      if (k == 0) cmp("drain_inflight_start", inflight, 2);
      cmp("drain_no_grant", grant, 0);
      if (res_valid && res_ready) last_x = k;
      if (drained && first_d < 0) first_d = k;
      post();
    end
    cmp("drain_last_xfer", last_x, 2);
    cmp("drained_timing", first_d, last_x + 1);
    drive(1, 1, 1, 0, 0); pre();
    cmp("undrain_still_quiet", start, 0);
    post();
    drive(1, 1, 1, 0, 0); pre();
    cmp("undrain_resume", start, 1);
    post();

    // Flush during drain empties immediately.
    empty_pipe();
    drive(1, 1, 1, 0, 0); pre(); post();
    drive(1, 1, 1, 0, 0); pre(); post();
    drive(1, 1, 0, 1, 0); pre(); post();
    drive(1, 1, 0, 1, 1); pre();
    cmp("drain_flush_not_yet", drained, 0);
    post();
    drive(1, 1, 0, 1, 0); pre();
    cmp("drain_flush_drained", drained, 1);
    post();
    drive(0, 0, 1, 0, 0); pre(); post();

    // Reset in the middle of traffic.
    for (int i = 0; i < 4; i++) begin drive(1, 1, 1, 0, 0); pre(); post(); end
    rst = 1'b1;
    drive(1, 1, 1, 0, 0); pre(); post();
    drive(1, 1, 1, 0, 0); pre(); check_reset(); post();
    rst = 1'b0;
    drive(1, 1, 1, 0, 0); pre();
    cmp("rerst_idle_grant", grant, 0);
    post();
    drive(1, 1, 1, 0, 0); pre();
    cmp("rerst_first_grant", grant, 2'b01);
    post();

    // Random traffic.
    begin
      bit dr;
      dr = 1'b0;
      for (int i = 0; i < 2000; i++) begin
        if ($urandom_range(0, 29) == 0) dr = ~dr;
        rst = ($urandom_range(0, 199) == 0);
        drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, $urandom_range(0, 3) != 0,
              dr, $urandom_range(0, 49) == 0);
        pre(); post();
      end
      rst = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
